// File: rtl/clk_div.sv
`default_nettype none
// -- clk_div: free-running 2^clk divider producing CPU_clk and its pre-rise strobe
// -- Rev 1.0
module clk_div #(
  parameter int unsigned clk = 3
) (
  input  logic clk_100M,
  input  logic init_rst,
  output logic CPU_clk,
  output logic cpu_clk_en
);

  localparam int unsigned CNT_W = clk;
  // Count value one cycle before the MSB goes high.
  localparam logic [CNT_W-1:0] EN_VAL = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_100M or posedge init_rst) begin
    if (init_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CPU_clk    = cnt_q[CNT_W-1];
  assign cpu_clk_en = (cnt_q == EN_VAL);

endmodule
`default_nettype wire

// File: rtl/clk_reset_gen.sv
`default_nettype none
// -- clk_reset_gen: divided CPU clock plus reset button sampled once per CPU_clk period
// -- Rev 1.0
module clk_reset_gen #(
  parameter int unsigned clk = 3
) (
  input  logic clk_100M,
  input  logic init_rst,
  input  logic res,
  output logic CPU_clk,
  output logic cpu_clk_en,
  output logic reset
);

  localparam int unsigned CNT_W = clk;

  logic reset_q;
  logic reset_d;

  clk_div #(
    .clk(CNT_W)
  ) u_div (
    .clk_100M  (clk_100M),
    .init_rst  (init_rst),
    .CPU_clk   (CPU_clk),
    .cpu_clk_en(cpu_clk_en)
  );

  // Capture lands on the same edge where CPU_clk rises, so reset is stable across a full period.
  always_comb begin
    reset_d = cpu_clk_en ? res : reset_q;
  end

  always_ff @(posedge clk_100M or posedge init_rst) begin
    if (init_rst) begin
      reset_q <= 1'b1;
    end else begin
      reset_q <= reset_d;
    end
  end

  assign reset = reset_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_reset_gen.sv
`default_nettype none
// -- tb_clk_reset_gen: directed table plus randomized model check for clk = 1, 3, 5
// -- Rev 1.0
module tb_clk_reset_gen;

  logic clk_100M = 1'b0;
  logic init_rst = 1'b1;
  logic res      = 1'b0;
  logic [2:0] cpu_w;
  logic [2:0] en_w;
  logic [2:0] rst_w;

  always #5 clk_100M = ~clk_100M;

  clk_reset_gen #(.clk(1)) u_k1 (
    .clk_100M(clk_100M), .init_rst(init_rst), .res(res),
    .CPU_clk(cpu_w[0]), .cpu_clk_en(en_w[0]), .reset(rst_w[0]));
  clk_reset_gen #(.clk(3)) u_k3 (
    .clk_100M(clk_100M), .init_rst(init_rst), .res(res),
    .CPU_clk(cpu_w[1]), .cpu_clk_en(en_w[1]), .reset(rst_w[1]));
  clk_reset_gen #(.clk(5)) u_k5 (
    .clk_100M(clk_100M), .init_rst(init_rst), .res(res),
    .CPU_clk(cpu_w[2]), .cpu_clk_en(en_w[2]), .reset(rst_w[2]));

  typedef struct {
    logic res_next;
    logic cpu;
    logic en;
    logic rst;
  } vec_t;

  vec_t tbl[37];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_edges  = 0;
  int   kv[3]    = '{1, 3, 5};
  logic ref_rst[3];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t edge=%0d: got %b expected %b", name, $time, n_edges, act, exp);
    end
  endtask

  // Model: edges counted since release; CPU_clk high in the upper half of each period.
  function automatic logic exp_cpu(input int k, input int n);
    return (n % (1 << k)) >= (1 << (k - 1));
  endfunction

  function automatic logic exp_en(input int k, input int n);
    return (n % (1 << k)) == ((1 << (k - 1)) - 1);
  endfunction

  task automatic model_async_reset();
    n_edges = 0;
    for (int j = 0; j < 3; j++) ref_rst[j] = 1'b1;
  endtask

  task automatic step();
    logic rp;
    logic ip;
    rp = res;
    ip = init_rst;
    @(posedge clk_100M);
    if (!ip) begin
      n_edges++;
      for (int j = 0; j < 3; j++) begin
        if ((n_edges % (1 << kv[j])) == (1 << (kv[j] - 1))) ref_rst[j] = rp;
      end
    end
    #1;
  endtask

  task automatic check_model();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("k%0d_cpu_clk", kv[j]), cpu_w[j], exp_cpu(kv[j], n_edges));
      chk($sformatf("k%0d_clk_en", kv[j]), en_w[j], exp_en(kv[j], n_edges));
      chk($sformatf("k%0d_reset", kv[j]), rst_w[j], ref_rst[j]);
    end
  endtask

  initial begin
    // Directed clk=3 sequence: capture at edges 4,12,20,28,36; res rises after edge 6,
    // a 3-cycle glitch after edge 20, and res changes just before and just after edge 36.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[27] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[28] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[29] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[30] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[31] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[32] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[33] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[34] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[35] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[36] = '{1'b0, 1'b1, 1'b0, 1'b1};

    model_async_reset();
    init_rst = 1'b1;
    res      = 1'b0;
    repeat (2) step();
    check_model();
    chk("k3_cnt_in_reset", (u_k3.u_div.cnt_q == 3'd0), 1'b1);
    init_rst = 1'b0;

    for (int i = 0; i < 37; i++) begin
      step();
      chk($sformatf("tbl%0d_cpu_clk", i), cpu_w[1], tbl[i].cpu);
      chk($sformatf("tbl%0d_clk_en", i), en_w[1], tbl[i].en);
      chk($sformatf("tbl%0d_reset", i), rst_w[1], tbl[i].rst);
      check_model();
      res = tbl[i].res_next;
    end

    // Mid-count asynchronous reset: outputs must change before the next clock edge.
    repeat (3) step();
    #3;
    init_rst = 1'b1;
    #1;
    model_async_reset();
    check_model();
    chk("k3_cnt_async", (u_k3.u_div.cnt_q == 3'd0), 1'b1);
    repeat (2) step();
    check_model();
    init_rst = 1'b0;

    for (int i = 0; i < 700; i++) begin
      step();
      check_model();
      if ($urandom_range(0, 3) == 0) res = ~res;
      if ($urandom_range(0, 99) == 0) begin
        #3;
        init_rst = 1'b1;
        #1;
        model_async_reset();
        check_model();
        step();
        check_model();
        init_rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
